// File: rtl/phase_sine_cordic.sv
// -----------------------------------------------------------------------------
// phase_sine_cordic
//
// Converts a 16-bit phase word (65536 units per turn, 0x4000 = pi/2) into a
// signed sine sample, full scale +/-32767. It uses an iterative rotation-mode
// CORDIC that runs one micro-rotation per clock. Input and output each have a
// valid/ready handshake. The block sits between the phase-accumulator bank and
// the voice mixer / DAC path.
//
// Ports
//   clk         system clock, every register updates on posedge
//   rst         synchronous active-high reset; drops any in-flight sample
//   phase_in    unsigned phase word
//   in_valid    phase_in is valid this cycle
//   in_ready    block can take a phase word this cycle (IDLE only)
//   sample_out  signed sine sample, held stable while out_valid is high
//   out_valid   sample_out carries a completed result
//   out_ready   downstream takes sample_out this cycle
//
// Parameters
//   ITER   number of CORDIC micro-rotations (8..16)
//   GUARD  extra LSBs carried on the x/y datapath (>= 1)
//
// Timing: a word accepted on edge 0 is rotated on edges 1..ITER, and
// out_valid is high right after edge ITER. When out_ready is held high, the
// output handshake happens on edge ITER+1 and the next word can be accepted on
// edge ITER+2.
// -----------------------------------------------------------------------------
module phase_sine_cordic #(
  parameter int ITER  = 14,
  parameter int GUARD = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        phase_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic signed [15:0] sample_out,
  output logic               out_valid,
  input  logic               out_ready
);

  // x/y width: 16-bit sample + guard bits + one headroom bit for CORDIC gain
  localparam int W  = 16 + GUARD + 1;
  // Angles carry 4 fractional phase-unit bits. Without them, the rounding in
  // an integer arctangent table alone can push the result past 3 LSB.
  localparam int ZF = 4;
  localparam int ZW = 18 + ZF;
  // Width used for the final correction and rounding arithmetic
  localparam int RW = W + 2;

  // 19898 = round(0.607253 * 32767) pre-scales x by the inverse CORDIC gain
  localparam logic signed [W-1:0]  X_INIT = W'(19898 <<< GUARD);
  localparam logic signed [RW-1:0] HALF   = RW'(1 <<< (GUARD - 1));
  localparam logic signed [RW-1:0] SAT_P  = RW'(32767);
  localparam logic signed [RW-1:0] SAT_N  = RW'(-32767);
  localparam logic [4:0]           LAST   = 5'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ROTATE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // atan(2^-i) in phase units, scaled by 2^ZF. Each entry rounded to whole
  // phase units gives 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10,
  // 5, 3, 1, 1, 0.
  function automatic logic signed [ZW-1:0] atan_lut(input logic [4:0] idx);
    case (idx)
      5'd0:    atan_lut = ZW'(131072);
      5'd1:    atan_lut = ZW'(77376);
      5'd2:    atan_lut = ZW'(40884);
      5'd3:    atan_lut = ZW'(20753);
      5'd4:    atan_lut = ZW'(10417);
      5'd5:    atan_lut = ZW'(5213);
      5'd6:    atan_lut = ZW'(2607);
      5'd7:    atan_lut = ZW'(1304);
      5'd8:    atan_lut = ZW'(652);
      5'd9:    atan_lut = ZW'(326);
      5'd10:   atan_lut = ZW'(163);
      5'd11:   atan_lut = ZW'(81);
      5'd12:   atan_lut = ZW'(41);
      5'd13:   atan_lut = ZW'(20);
      5'd14:   atan_lut = ZW'(10);
      5'd15:   atan_lut = ZW'(5);
      default: atan_lut = '0;
    endcase
  endfunction

  // Round half up by adding half an LSB, drop the guard bits, then clamp to
  // the symmetric range +/-32767.
  function automatic logic signed [15:0] round_sat(input logic signed [RW-1:0] v);
    logic signed [RW-1:0] r;
    r = (v + HALF) >>> GUARD;
    if (r > SAT_P) begin
      r = SAT_P;
    end else if (r < SAT_N) begin
      r = SAT_N;
    end
    round_sat = 16'(r);
  endfunction

  logic signed [W-1:0]  r_x;
  logic signed [W-1:0]  r_y;
  logic signed [ZW-1:0] r_z;
  logic [4:0]           r_i;
  logic                 r_neg;
  logic signed [15:0]   r_sample;

  logic [15:0]          w_fold;
  logic                 w_fold_neg;
  logic [15:0]          w_fold_mag;
  logic                 w_pos;
  logic                 w_last;
  logic signed [W-1:0]  w_xs;
  logic signed [W-1:0]  w_ys;
  logic signed [W-1:0]  w_x_nxt;
  logic signed [W-1:0]  w_y_nxt;
  logic signed [ZW-1:0] w_at;
  logic signed [ZW-1:0] w_z_nxt;
  logic signed [RW-1:0] w_corr;
  logic signed [RW-1:0] w_y_fin;
  logic signed [15:0]   w_mag_s;
  logic signed [15:0]   w_sample;

  // Fold the second and third quadrants onto [-pi/2, +pi/2] using
  // sin(pi - a) = sin(a). The result is a signed angle in [-0x4000, 0x4000].
  assign w_fold     = (phase_in[15] ^ phase_in[14]) ? (16'h8000 - phase_in) : phase_in;
  assign w_fold_neg = w_fold[15];
  // The rotation always runs on |angle|, and the sign is applied at the end.
  // As a result, sample(p) and sample(p + 0x8000) are exact negatives.
  assign w_fold_mag = w_fold_neg ? (16'd0 - w_fold) : w_fold;

  assign w_pos   = ~r_z[ZW-1];
  assign w_last  = (r_i == LAST);
  assign w_xs    = r_x >>> r_i;
  assign w_ys    = r_y >>> r_i;
  assign w_at    = atan_lut(r_i);
  assign w_x_nxt = w_pos ? (r_x - w_ys) : (r_x + w_ys);
  assign w_y_nxt = w_pos ? (r_y + w_xs) : (r_y - w_xs);
  assign w_z_nxt = w_pos ? (r_z - w_at) : (r_z + w_at);

  // The residual angle left after the last micro-rotation is applied as a
  // small-angle step, y += x * z_rad. Here z_rad = z * 2*pi / 2^20, and
  // 2*pi / 2^20 is approximately 6434 / 2^30.
  assign w_corr   = RW'((64'(w_x_nxt) * 64'(w_z_nxt) * 64'sd6434) >>> 30);
  assign w_y_fin  = RW'(w_y_nxt) + w_corr;
  assign w_mag_s  = round_sat(w_y_fin);
  assign w_sample = r_neg ? -w_mag_s : w_mag_s;

  assign sample_out = r_sample;

  // ---- control: state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---- control: next state and handshake outputs ----
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = S_ROTATE;
        end
      end
      S_ROTATE: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        // Going back to IDLE means no new word is taken in this same cycle
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---- datapath: load, rotate, and capture the result ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x      <= '0;
      r_y      <= '0;
      r_z      <= '0;
      r_i      <= '0;
      r_neg    <= 1'b0;
      r_sample <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x   <= X_INIT;
            r_y   <= '0;
            r_z   <= signed'(ZW'({w_fold_mag, {ZF{1'b0}}}));
            r_i   <= '0;
            r_neg <= w_fold_neg;
          end
        end
        S_ROTATE: begin
          r_x <= w_x_nxt;
          r_y <= w_y_nxt;
          r_z <= w_z_nxt;
          r_i <= r_i + 5'd1;
          if (w_last) begin
            r_sample <= w_sample;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
